// File: rtl/dsp_wresp_arbiter.sv
// dsp_wresp_arbiter: round-robin merge of slave write responses into one registered master B slot,
// with an outstanding-write counter that stalls the master AW channel at its limit.
module dsp_wresp_arbiter #(
    parameter int SLV_AMT = 2,
    parameter int OUTSTANDING_AMT = 8,
    parameter int TRANS_MST_ID_W = 5,
    parameter int TRANS_WR_RESP_W = 2
) (
    input  logic                                 ACLK_i,
    input  logic                                 ARESETn_i,
    input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]    sa_BID_i,
    input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]   sa_BRESP_i,
    input  logic [SLV_AMT-1:0]                   sa_BVALID_i,
    output logic [SLV_AMT-1:0]                   sa_BREADY_o,
    output logic [TRANS_MST_ID_W-1:0]            m_BID_o,
    output logic [TRANS_WR_RESP_W-1:0]           m_BRESP_o,
    output logic                                 m_BVALID_o,
    input  logic                                 m_BREADY_i,
    input  logic                                 AW_shift_en_i,
    output logic                                 AW_stall_o
);
    localparam int PW = SLV_AMT > 1 ? $clog2(SLV_AMT) : 1;
    localparam int CW = $clog2(OUTSTANDING_AMT + 1);
    logic [PW-1:0] rr_ptr, gnt;
    logic [CW-1:0] cnt;
    logic found, load_en, hs, m_hs;
    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % SLV_AMT);
    endfunction
    assign load_en = ~m_BVALID_o | m_BREADY_i;
    assign m_hs = m_BVALID_o & m_BREADY_i;
    // first valid slave at or after rr_ptr, wrapping around
    always_comb begin
        gnt = '0;
        found = 1'b0;
        for (int i = 0; i < SLV_AMT; i++) begin
            if (!found && sa_BVALID_i[wrap(int'(rr_ptr) + i)]) begin
                found = 1'b1;
                gnt = wrap(int'(rr_ptr) + i);
            end
        end
    end
    assign hs = ARESETn_i & found & load_en;
    assign sa_BREADY_o = hs ? SLV_AMT'(1) << gnt : '0;
    assign AW_stall_o = cnt == CW'(OUTSTANDING_AMT);
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            m_BID_o <= '0;
            m_BRESP_o <= '0;
            m_BVALID_o <= 1'b0;
            rr_ptr <= '0;
            cnt <= '0;
        end else begin
            if (hs) begin
                m_BID_o <= sa_BID_i[int'(gnt)*TRANS_MST_ID_W +: TRANS_MST_ID_W];
                m_BRESP_o <= sa_BRESP_i[int'(gnt)*TRANS_WR_RESP_W +: TRANS_WR_RESP_W];
                m_BVALID_o <= 1'b1;
                rr_ptr <= wrap(int'(gnt) + 1);
            end else if (m_hs) begin
                m_BVALID_o <= 1'b0;
            end
            if (AW_shift_en_i && !m_hs && !AW_stall_o)
                cnt <= cnt + 1'b1;
            else if (m_hs && !AW_shift_en_i && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end
    no_aw_when_stalled: assert property (@(posedge ACLK_i) disable iff (!ARESETn_i) !(AW_shift_en_i && AW_stall_o));
endmodule
